cmul_seq_signmag: RTL and testbench
===================================

Name: cmul_seq_signmag

Overview:
- Sequential complex multiplier for the QFT state-vector datapath.
- Computes one product (ar + j·ai)·(br + j·bi) using a single shared sign-magnitude fixed-point real multiplier, time-multiplexed over four partial products.
- Sits directly upstream of that real multiplier: it sequences operands into it and consumes its products.
- Sign-magnitude adders then combine the four partial products into a complex result, returned over a valid/ready interface.

Parameters:
DATA_W, 32, width of each real or imaginary component: bit DATA_W-1 is the sign, bits DATA_W-2:0 are the magnitude, value = magnitude / 2^(DATA_W-2).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept an operand set
a_re  input  DATA_W  operand A real part
a_im  input  DATA_W  operand A imaginary part
b_re  input  DATA_W  operand B real part
b_im  input  DATA_W  operand B imaginary part
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
p_re  output  DATA_W  result real part = ar·br − ai·bi
p_im  output  DATA_W  result imaginary part = ar·bi + ai·br
overflow  output  1  saturation occurred anywhere in this result

Behaviour:
- Reset, synchronous while rst_n=0:
  - state←IDLE.
  - in_ready=1, out_valid=0, p_re=0, p_im=0, overflow=0, all internal product registers 0.
  - Reset mid-operation abandons the operation; no result is emitted.
- FSM states: IDLE → M_AC → M_BD → M_AD → M_BC → ADD → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready (cycle T), capture all four operands and go to M_AC.
  - in_ready=0 in every other state; operand inputs are ignored outside IDLE.
- M_AC, M_BD, M_AD, M_BC (cycles T+1..T+4):
  - Each state drives one operand pair (ar·br, ai·bi, ar·bi, ai·br) to the real multiplier.
  - The product is registered at the end of that cycle.
- ADD (cycle T+5): registers p_re and p_im.
- DONE: out_valid=1 starting cycle T+6, so accept-to-valid latency is 6 cycles.
  - p_re, p_im and overflow are held stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE: out_valid=0 and in_ready=1 in the next cycle.
  - Throughput is one result per 7 cycles with out_ready tied high.
- Real multiply:
  - Sign = sA ^ sB.
  - Magnitude = (mA·mB) >> (DATA_W-2), truncated.
  - If the magnitude exceeds DATA_W-1 bits, saturate to {sign, all ones} and set the overflow flag.
- Sign-magnitude add/sub:
  - Subtraction flips the sign of the second operand.
  - Equal signs: add magnitudes; a carry out of bit DATA_W-2 saturates the magnitude to all ones, keeps the sign, and sets overflow.
  - Different signs: subtract the smaller magnitude from the larger and take the sign of the larger.
  - A zero result is always +0 (sign bit 0); −0 is never emitted.
  - A −0 input is treated as 0.
- overflow:
  - OR of the four product saturations and the two adder saturations for this result.
  - Cleared when a new operand set is accepted.
- Simultaneous events: rst_n=0 overrides any handshake in the same cycle.

Optional Feature:
CMUL_CONJ_EN:
- Defined: adds input port conj_b (1 bit), sampled with the operands in IDLE. When conj_b=1, the sign of b_im is inverted at capture, so the block computes A·conj(B). A b_im of zero is still treated as +0.
- Undefined: the port is absent and the block always computes A·B.

Test Plan:
- DATA_W=16, A=(0x2000,0x2000), B=(0x2000,0xA000) → p_re=0x2000, p_im=0x0000 (not 0x8000), overflow=0; out_valid first seen 6 cycles after acceptance.
- A=(0x4000,0x0000), B=(0x1234,0x9234) → p_re=0x1234, p_im=0x9234, overflow=0.
- A=(0x6000,0x0000), B=(0x6000,0x0000) → product saturates: p_re=0x7FFF, p_im=0x0000, overflow=1.
- A=(0x4000,0x4000), B=(0x4000,0x4000) → adder saturates: p_re=0x0000, p_im=0x7FFF, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid stays 1, p_re/p_im stay stable, in_ready=0, in_valid ignored; after out_ready=1 for one cycle → in_ready=1 next cycle.
- rst_n=0 for one cycle during M_AD → next cycle shows IDLE with in_ready=1, out_valid=0, outputs 0; a following transaction completes with correct values.

Source files
------------

// File: rtl/cmul_seq_signmag_if.sv
// rtl/cmul_seq_signmag_if.sv - operand/result handshake bundle for cmul_seq_signmag (conj_b present under CMUL_CONJ_EN)
interface cmul_seq_signmag_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_re;
    logic [DATA_W-1:0] a_im;
    logic [DATA_W-1:0] b_re;
    logic [DATA_W-1:0] b_im;
`ifdef CMUL_CONJ_EN
    logic              conj_b;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] p_re;
    logic [DATA_W-1:0] p_im;
    logic              overflow;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im,
`ifdef CMUL_CONJ_EN
        output conj_b,
`endif
        output out_ready,
        input  in_ready, out_valid, p_re, p_im, overflow
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im,
`ifdef CMUL_CONJ_EN
        input  conj_b,
`endif
        input  out_ready,
        output in_ready, out_valid, p_re, p_im, overflow
    );
endinterface

// File: rtl/cmul_seq_signmag.sv
// rtl/cmul_seq_signmag.sv - sequential sign-magnitude complex multiplier, one shared real multiplier (CMUL_CONJ_EN adds conj_b)
module cmul_seq_signmag #(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmul_seq_signmag_if.slave    bus
);
    localparam int MW   = DATA_W - 1;
    localparam int FRAC = DATA_W - 2;

    typedef enum logic [2:0] {
        IDLE, M_AC, M_BD, M_AD, M_BC, ADD, DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] ar, ai, br, bi;
    logic [DATA_W-1:0] prod_ac, prod_bd, prod_ad, prod_bc;
    logic [DATA_W-1:0] p_re_q, p_im_q;
    logic              ovf_q, in_ready_q, out_valid_q;

    logic [DATA_W-1:0] mul_x, mul_y;
    logic [DATA_W:0]   mul_res, add_re, add_im;
    logic [DATA_W-1:0] b_im_cap;

    // Results are packed as {saturated, sign, magnitude}.
    function automatic logic [DATA_W:0] sm_mul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        logic [2*MW-1:0] full;
        logic [2*MW-1:0] sh;
        logic            s;
        full = {{MW{1'b0}}, x[MW-1:0]} * {{MW{1'b0}}, y[MW-1:0]};
        sh   = full >> FRAC;
        s    = x[DATA_W-1] ^ y[DATA_W-1];
        if (|sh[2*MW-1:MW])
            return {1'b1, s, {MW{1'b1}}};
        else if (sh[MW-1:0] == '0)
            return '0;
        else
            return {1'b0, s, sh[MW-1:0]};
    endfunction

    function automatic logic [DATA_W:0] sm_add(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                               input logic sub);
        logic          sx, sy, s, sat;
        logic [MW-1:0] mx, my, mag;
        logic [MW:0]   sum;
        sx  = x[DATA_W-1];
        sy  = y[DATA_W-1] ^ sub;
        mx  = x[MW-1:0];
        my  = y[MW-1:0];
        sat = 1'b0;
        sum = '0;
        if (sx == sy) begin
            sum = {1'b0, mx} + {1'b0, my};
            sat = sum[MW];
            mag = sat ? {MW{1'b1}} : sum[MW-1:0];
            s   = sx;
        end else if (mx >= my) begin
            mag = mx - my;
            s   = sx;
        end else begin
            mag = my - mx;
            s   = sy;
        end
        // A -0 operand falls out naturally here; only the result sign needs forcing.
        if (mag == '0)
            s = 1'b0;
        return {sat, s, mag};
    endfunction

    always_comb begin
        mul_x = ar;
        mul_y = br;
        case (state)
            M_BD:    begin mul_x = ai; mul_y = bi; end
            M_AD:    begin mul_x = ar; mul_y = bi; end
            M_BC:    begin mul_x = ai; mul_y = br; end
            default: begin mul_x = ar; mul_y = br; end
        endcase
    end

    assign mul_res = sm_mul(mul_x, mul_y);
    assign add_re  = sm_add(prod_ac, prod_bd, 1'b1);
    assign add_im  = sm_add(prod_ad, prod_bc, 1'b0);

`ifdef CMUL_CONJ_EN
    assign b_im_cap = (bus.b_im[MW-1:0] == '0) ? '0 : {bus.b_im[DATA_W-1] ^ bus.conj_b, bus.b_im[MW-1:0]};
`else
    assign b_im_cap = bus.b_im;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ar          <= '0;
            ai          <= '0;
            br          <= '0;
            bi          <= '0;
            prod_ac     <= '0;
            prod_bd     <= '0;
            prod_ad     <= '0;
            prod_bc     <= '0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        ar         <= bus.a_re;
                        ai         <= bus.a_im;
                        br         <= bus.b_re;
                        bi         <= b_im_cap;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= M_AC;
                    end
                end
                M_AC: begin
                    prod_ac <= mul_res[DATA_W-1:0];
                    ovf_q   <= ovf_q | mul_res[DATA_W];
                    state   <= M_BD;
                end
                M_BD: begin
                    prod_bd <= mul_res[DATA_W-1:0];
                    ovf_q   <= ovf_q | mul_res[DATA_W];
                    state   <= M_AD;
                end
                M_AD: begin
                    prod_ad <= mul_res[DATA_W-1:0];
                    ovf_q   <= ovf_q | mul_res[DATA_W];
                    state   <= M_BC;
                end
                M_BC: begin
                    prod_bc <= mul_res[DATA_W-1:0];
                    ovf_q   <= ovf_q | mul_res[DATA_W];
                    state   <= ADD;
                end
                ADD: begin
                    p_re_q      <= add_re[DATA_W-1:0];
                    p_im_q      <= add_im[DATA_W-1:0];
                    ovf_q       <= ovf_q | add_re[DATA_W] | add_im[DATA_W];
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p_re      = p_re_q;
    assign bus.p_im      = p_im_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cmul_seq_signmag.sv
// tb/tb_cmul_seq_signmag.sv - directed scoreboard bench for cmul_seq_signmag at DATA_W=16
module tb_cmul_seq_signmag;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    cmul_seq_signmag_if #(.DATA_W(W)) bus ();

    cmul_seq_signmag #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a_re, input logic [W-1:0] a_im,
                        input logic [W-1:0] b_re, input logic [W-1:0] b_im,
                        input logic [W-1:0] e_re, input logic [W-1:0] e_im, input logic e_ovf);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.a_re = a_re; bus.a_im = a_im; bus.b_re = b_re; bus.b_im = b_im;
        bus.in_valid = 1'b1;
        e.re = e_re; e.im = e_im; e.ovf = e_ovf;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called on the negedge right after acceptance; returns count of cycles until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_p_re"}, {16'd0, bus.p_re}, {16'd0, e.re});
            check({tag, "_p_im"}, {16'd0, bus.p_im}, {16'd0, e.im});
            check({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
        end
    endtask

    task automatic run_txn(input string tag,
                           input logic [W-1:0] a_re, input logic [W-1:0] a_im,
                           input logic [W-1:0] b_re, input logic [W-1:0] b_im,
                           input logic [W-1:0] e_re, input logic [W-1:0] e_im, input logic e_ovf);
        int lat;
        send(a_re, a_im, b_re, b_im, e_re, e_im, e_ovf);
        wait_valid(lat);
        check({tag, "_latency"}, lat, 32'd6);
        compare_result(tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_out_valid_cleared"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] hold_re, hold_im;
        exp_t         dropped;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_p_re", {16'd0, bus.p_re}, 32'd0);
        check("reset_p_im", {16'd0, bus.p_im}, 32'd0);
        check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn("t1_zero_im", 16'h2000, 16'h2000, 16'h2000, 16'hA000, 16'h2000, 16'h0000, 1'b0);
        run_txn("t2_unit", 16'h4000, 16'h0000, 16'h1234, 16'h9234, 16'h1234, 16'h9234, 1'b0);
        run_txn("t3_mul_sat", 16'h6000, 16'h0000, 16'h6000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
        run_txn("t4_add_sat", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h7FFF, 1'b1);
        // 0.5 * (-0.75 + j0.25) = -0.375 + j0.125; overflow from t4 must not leak through.
        run_txn("t5_neg", 16'h2000, 16'h0000, 16'hB000, 16'h1000, 16'h9800, 16'h0800, 1'b0);

        // Backpressure
        bus.out_ready = 1'b0;
        send(16'h4000, 16'h0000, 16'h1234, 16'h9234, 16'h1234, 16'h9234, 1'b0);
        wait_valid(lat);
        check("bp_latency", lat, 32'd6);
        hold_re = bus.p_re;
        hold_im = bus.p_im;
        bus.in_valid = 1'b1;
        bus.a_re = 16'h6000; bus.b_re = 16'h6000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
            check("bp_p_re_stable", {16'd0, bus.p_re}, {16'd0, hold_re});
            check("bp_p_im_stable", {16'd0, bus.p_im}, {16'd0, hold_im});
            check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        compare_result("bp");
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("bp_out_valid_after", {31'd0, bus.out_valid}, 32'd0);

        // Reset during M_AD abandons the operation
        send(16'h2000, 16'h2000, 16'h2000, 16'hA000, 16'h2000, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dropped = sb.pop_back();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_p_re", {16'd0, bus.p_re}, 32'd0);
        check("rst_p_im", {16'd0, bus.p_im}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        repeat (8) @(negedge clk);
        check("rst_no_result", {31'd0, bus.out_valid}, 32'd0);
        run_txn("t6_after_rst", 16'h6000, 16'h0000, 16'h6000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
